// File: rtl/chan_pkg.sv
// Shared types for the byte-wide channel arbiter.
//   byte_t      : one channel beat of payload
//   arb_state_t : arbiter control state (IDLE waits for a request, XFER moves one packet)
package chan_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic {IDLE, XFER} arb_state_t;

endpackage

// File: rtl/chan_if.sv
// Byte-wide streaming channel bundle.
//   data  : payload byte (chan_pkg::byte_t)
//   valid : beat present
//   ready : consumer accepts the beat
//   last  : beat closes the packet
// Modports: src drives data/valid/last, snk drives ready.
interface chan_if;
    import chan_pkg::*;

    byte_t data;
    logic  valid;
    logic  ready;
    logic  last;

    modport src (output data, output valid, output last, input ready);
    modport snk (input data, input valid, input last, output ready);

endinterface

// File: rtl/chan_share_arbiter_rr_pick.sv
// Round-robin picker, purely combinational.
//   req_i   : request vector
//   last_i  : index of the previous owner; search starts just above it and wraps
//   pick_o  : one-hot winner (zero when no request)
//   idx_o   : index of the winner
//   found_o : at least one request present
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [NREQ-1:0] pick_o,
    output logic [IDXW-1:0] idx_o,
    output logic            found_o
);

    always_comb begin
        int unsigned j;
        j       = 0;
        pick_o  = '0;
        idx_o   = '0;
        found_o = 1'b0;
        // k runs 1..NREQ so the previous owner is visited last.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            j = (int'(last_i) + k) % NREQ;
            if (!found_o && req_i[IDXW'(j)]) begin
                found_o            = 1'b1;
                idx_o              = IDXW'(j);
                pick_o[IDXW'(j)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chan_share_arbiter.sv
// Packet-granular round-robin arbiter sharing one byte channel among NREQ producers.
//   clk, rst_n      : clock and synchronous active-low reset
//   req_valid/data/last, req_ready : per-requester streams (requester i at data[8i+7:8i])
//   out_valid/data/last, out_ready : shared downstream channel
//   grant           : one-hot current owner, zero while idle
//   overrun         : sticky, set when a packet is cut at MAX_BEATS beats
module chan_share_arbiter
    import chan_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    output byte_t             out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [NREQ-1:0]   grant,
    output logic              overrun
);

    localparam int unsigned IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]  LastBeat = 8'(MAX_BEATS - 1);

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic            overrun_q, overrun_d;

    logic [NREQ-1:0] pick;
    logic [IDXW-1:0] pick_idx;
    logic            pick_found;
    logic            handshake;

    chan_if out_ch ();

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req_i   (req_valid),
        .last_i  (owner_q),
        .pick_o  (pick),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign out_ch.ready = out_ready;

    // Owner's stream is passed straight through while a packet is in flight.
    always_comb begin
        out_ch.valid = 1'b0;
        out_ch.data  = '0;
        out_ch.last  = 1'b0;
        req_ready    = '0;
        if (state_q == XFER) begin
            out_ch.valid       = req_valid[owner_q];
            out_ch.data        = req_data[{owner_q, 3'b000} +: 8];
            out_ch.last        = req_last[owner_q] || (beat_cnt_q == LastBeat);
            req_ready[owner_q] = out_ch.ready;
        end
    end

    assign handshake = out_ch.valid && out_ch.ready;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        overrun_d  = overrun_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick;
                    owner_d = pick_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (handshake) begin
                    if (out_ch.last) begin
                        beat_cnt_d = '0;
                        grant_d    = '0;
                        state_d    = IDLE;
                        // Cut by the beat limit rather than by the producer's marker.
                        if (!req_last[owner_q]) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= IDXW'(NREQ - 1);
            beat_cnt_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    assign out_valid = out_ch.valid;
    assign out_data  = out_ch.data;
    assign out_last  = out_ch.last;
    assign grant     = grant_q;
    assign overrun   = overrun_q;

endmodule
